// File: rtl/snoop_coherence_array_if.sv
// Handshake and bus bundle for snoop_coherence_array.
// master = CPU/bus/memory side, slave = the coherence array.
interface snoop_coherence_array_if #(
  parameter int IDX_W = 4
);
  localparam int NUM_LINES = 2 ** IDX_W;

  logic                   init_valid;
  logic [IDX_W-1:0]       init_idx;
  logic [1:0]             init_state;
  logic                   snp_valid;
  logic                   snp_ready;
  logic [2:0]             snp_op;
  logic [IDX_W-1:0]       snp_idx;
  logic                   writeback_block;
  logic                   abort_mem_accs;
  logic [IDX_W-1:0]       wb_idx;
  logic                   wb_ack;
  logic                   cpu_valid;
  logic                   cpu_ready;
  logic                   cpu_write;
  logic [IDX_W-1:0]       cpu_idx;
  logic                   bus_req_valid;
  logic [2:0]             bus_req_op;
  logic [IDX_W-1:0]       bus_req_idx;
  logic [2*NUM_LINES-1:0] line_state;

  modport master (
    output init_valid, init_idx, init_state,
    output snp_valid, snp_op, snp_idx, wb_ack,
    output cpu_valid, cpu_write, cpu_idx,
    input  snp_ready, writeback_block,
    input  abort_mem_accs, wb_idx,
    input  cpu_ready, bus_req_valid,
    input  bus_req_op, bus_req_idx, line_state
  );

  modport slave (
    input  init_valid, init_idx, init_state,
    input  snp_valid, snp_op, snp_idx, wb_ack,
    input  cpu_valid, cpu_write, cpu_idx,
    output snp_ready, writeback_block,
    output abort_mem_accs, wb_idx,
    output cpu_ready, bus_req_valid,
    output bus_req_op, bus_req_idx, line_state
  );
endinterface

// File: rtl/snoop_coherence_array.sv
// Multi-line MSI-style snoop coherence array.
// Optional COH_PROTO_ERR_EN adds a sticky proto_err output.
module snoop_coherence_array #(
  parameter int IDX_W = 4
) (
  input  logic clock,
  input  logic reset,
`ifdef COH_PROTO_ERR_EN
  output logic proto_err,
`endif
  snoop_coherence_array_if.slave bus
);
  localparam int NUM_LINES = 2 ** IDX_W;

  typedef enum logic {IDLE, WRITEBACK} fsm_t;

  fsm_t             fsm;
  logic [1:0]       lines    [NUM_LINES];
  logic [1:0]       lines_nx [NUM_LINES];
  logic             snp_acc;
  logic             cpu_acc;
  logic             snp_op_ok;
  logic [1:0]       snp_cur;
  logic [1:0]       cpu_cur;
  logic             wb_go;
  logic             bus_go;
  logic [2:0]       bus_op_nx;
  logic             wb_flag;
  logic             abort_flag;
  logic [IDX_W-1:0] wb_idx_q;
  logic             bus_v_q;
  logic [2:0]       bus_op_q;
  logic [IDX_W-1:0] bus_idx_q;
`ifdef COH_PROTO_ERR_EN
  logic             perr_nx;
  logic             perr_q;
`endif

  assign bus.snp_ready = (fsm == IDLE) && !bus.init_valid;
  assign bus.cpu_ready = (fsm == IDLE) && !bus.init_valid &&
    !(bus.snp_valid && (bus.snp_idx == bus.cpu_idx));

  assign snp_acc   = bus.snp_valid && bus.snp_ready;
  assign cpu_acc   = bus.cpu_valid && bus.cpu_ready;
  assign snp_op_ok = (bus.snp_op == 3'b001) ||
                     (bus.snp_op == 3'b010) ||
                     (bus.snp_op == 3'b011);
  assign snp_cur   = lines[bus.snp_idx];
  assign cpu_cur   = lines[bus.cpu_idx];

  assign bus.writeback_block = wb_flag;
  assign bus.abort_mem_accs  = abort_flag;
  assign bus.wb_idx          = wb_idx_q;
  assign bus.bus_req_valid   = bus_v_q;
  assign bus.bus_req_op      = bus_op_q;
  assign bus.bus_req_idx     = bus_idx_q;
`ifdef COH_PROTO_ERR_EN
  assign proto_err = perr_q;
`endif

  // Next line states from preload, snoop and CPU requests.
  always_comb begin
    lines_nx  = lines;
    wb_go     = 1'b0;
    bus_go    = 1'b0;
    bus_op_nx = 3'b000;
`ifdef COH_PROTO_ERR_EN
    perr_nx   = 1'b0;
`endif
    if (bus.init_valid)
      lines_nx[bus.init_idx] = bus.init_state;
    if (snp_acc && snp_op_ok) begin
      unique case (snp_cur)
        2'b01: begin
          if (bus.snp_op != 3'b001)
            lines_nx[bus.snp_idx] = 2'b00;
        end
        2'b10: begin
          unique case (1'b1)
            bus.snp_op == 3'b001: begin
              lines_nx[bus.snp_idx] = 2'b01;
              wb_go = 1'b1;
            end
            bus.snp_op == 3'b010: begin
              lines_nx[bus.snp_idx] = 2'b00;
              wb_go = 1'b1;
            end
            default: begin
`ifdef COH_PROTO_ERR_EN
              perr_nx = 1'b1;
`endif
            end
          endcase
        end
        2'b11: begin
`ifdef COH_PROTO_ERR_EN
          lines_nx[bus.snp_idx] = 2'b00;
          perr_nx = 1'b1;
`endif
        end
        default: ;
      endcase
    end
    if (cpu_acc) begin
      unique case (cpu_cur)
        2'b01: begin
          if (bus.cpu_write) begin
            lines_nx[bus.cpu_idx] = 2'b10;
            bus_go    = 1'b1;
            bus_op_nx = 3'b011;
          end
        end
        2'b10: ;
`ifdef COH_PROTO_ERR_EN
        2'b11: begin
          lines_nx[bus.cpu_idx] = 2'b00;
          perr_nx = 1'b1;
        end
`endif
        default: begin
          bus_go = 1'b1;
          if (bus.cpu_write) begin
            lines_nx[bus.cpu_idx] = 2'b10;
            bus_op_nx = 3'b010;
          end else begin
            lines_nx[bus.cpu_idx] = 2'b01;
            bus_op_nx = 3'b001;
          end
        end
      endcase
    end
  end

  // Line state storage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LINES; i++)
        lines[i] <= 2'b00;
    end else begin
      lines <= lines_nx;
    end
  end

  // Flat view of all line states.
  always_comb begin
    bus.line_state = '0;
    for (int i = 0; i < NUM_LINES; i++)
      bus.line_state[2*i +: 2] = lines[i];
  end

  // Snoop FSM with registered writeback/abort outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm        <= IDLE;
      wb_flag    <= 1'b0;
      abort_flag <= 1'b0;
      wb_idx_q   <= '0;
    end else begin
      unique case (fsm)
        IDLE: begin
          if (wb_go) begin
            fsm        <= WRITEBACK;
            wb_flag    <= 1'b1;
            abort_flag <= 1'b1;
            wb_idx_q   <= bus.snp_idx;
          end
        end
        WRITEBACK: begin
          if (bus.wb_ack) begin
            fsm        <= IDLE;
            wb_flag    <= 1'b0;
            abort_flag <= 1'b0;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  // One-cycle bus transaction pulse for CPU misses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus_v_q   <= 1'b0;
      bus_op_q  <= 3'b000;
      bus_idx_q <= '0;
    end else begin
      bus_v_q   <= bus_go;
      bus_op_q  <= bus_go ? bus_op_nx : 3'b000;
      bus_idx_q <= bus_go ? bus.cpu_idx : '0;
    end
  end

`ifdef COH_PROTO_ERR_EN
  // Sticky protocol error flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      perr_q <= 1'b0;
    else if (perr_nx)
      perr_q <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_snoop_coherence_array.sv
// Self-checking bench for snoop_coherence_array.
// Table of single-request vectors plus multi-cycle sequences.
module tb_snoop_coherence_array;
  logic clock;
  logic reset;
`ifdef COH_PROTO_ERR_EN
  logic proto_err;
`endif

  snoop_coherence_array_if #(.IDX_W(4)) bus ();

  snoop_coherence_array #(.IDX_W(4)) dut (
    .clock(clock),
    .reset(reset),
`ifdef COH_PROTO_ERR_EN
    .proto_err(proto_err),
`endif
    .bus(bus.slave)
  );

  typedef struct {
    bit         cpu;
    logic [2:0] op;
    bit         wr;
    logic [3:0] idx;
    logic [1:0] pre;
    logic [1:0] post;
    bit         wb;
    bit         bv;
    logic [2:0] bop;
  } vec_t;

  typedef struct {
    logic [3:0] idx;
    logic [1:0] st;
    bit         wb;
    bit         bv;
    logic [2:0] bop;
  } exp_t;

  exp_t sbq[$];
  vec_t vt[16];
  int checks = 0;
  int failures = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] st_of(input logic [3:0] i);
    logic [31:0] ls;
    ls = bus.line_state;
    return ls[2*i +: 2];
  endfunction

  task automatic preload(input logic [3:0] i,
                         input logic [1:0] s);
    bus.init_valid = 1'b1;
    bus.init_idx   = i;
    bus.init_state = s;
    tick();
    bus.init_valid = 1'b0;
  endtask

  task automatic snoop(input logic [2:0] op,
                       input logic [3:0] i);
    bus.snp_valid = 1'b1;
    bus.snp_op    = op;
    bus.snp_idx   = i;
  endtask

  task automatic cpu(input bit w, input logic [3:0] i);
    bus.cpu_valid = 1'b1;
    bus.cpu_write = w;
    bus.cpu_idx   = i;
  endtask

  task automatic idle_inputs();
    bus.snp_valid = 1'b0;
    bus.cpu_valid = 1'b0;
  endtask

  initial begin
    exp_t e;
    vec_t v;
    vt[0]  = '{0, 3'b001, 0, 4'd0,  2'b00, 2'b00, 0, 0, 3'b000};
    vt[1]  = '{0, 3'b001, 0, 4'd1,  2'b01, 2'b01, 0, 0, 3'b000};
    vt[2]  = '{0, 3'b010, 0, 4'd5,  2'b01, 2'b00, 0, 0, 3'b000};
    vt[3]  = '{0, 3'b011, 0, 4'd6,  2'b01, 2'b00, 0, 0, 3'b000};
    vt[4]  = '{0, 3'b001, 0, 4'd3,  2'b10, 2'b01, 1, 0, 3'b000};
    vt[5]  = '{0, 3'b010, 0, 4'd8,  2'b10, 2'b00, 1, 0, 3'b000};
    vt[6]  = '{0, 3'b011, 0, 4'd9,  2'b10, 2'b10, 0, 0, 3'b000};
    vt[7]  = '{0, 3'b000, 0, 4'd10, 2'b10, 2'b10, 0, 0, 3'b000};
    vt[8]  = '{0, 3'b101, 0, 4'd11, 2'b10, 2'b10, 0, 0, 3'b000};
    vt[9]  = '{0, 3'b010, 0, 4'd12, 2'b00, 2'b00, 0, 0, 3'b000};
    vt[10] = '{1, 3'b000, 0, 4'd13, 2'b00, 2'b01, 0, 1, 3'b001};
    vt[11] = '{1, 3'b000, 0, 4'd14, 2'b01, 2'b01, 0, 0, 3'b000};
    vt[12] = '{1, 3'b000, 0, 4'd15, 2'b10, 2'b10, 0, 0, 3'b000};
    vt[13] = '{1, 3'b000, 1, 4'd7,  2'b00, 2'b10, 0, 1, 3'b010};
    vt[14] = '{1, 3'b000, 1, 4'd2,  2'b01, 2'b10, 0, 1, 3'b011};
    vt[15] = '{1, 3'b000, 1, 4'd4,  2'b10, 2'b10, 0, 0, 3'b000};

    reset = 1'b1;
    bus.init_valid = 1'b0;
    bus.init_idx   = '0;
    bus.init_state = '0;
    bus.snp_valid  = 1'b0;
    bus.snp_op     = '0;
    bus.snp_idx    = '0;
    bus.wb_ack     = 1'b0;
    bus.cpu_valid  = 1'b0;
    bus.cpu_write  = 1'b0;
    bus.cpu_idx    = '0;
    #12;
    chk("rst_lines", bus.line_state, 32'h0);
    chk("rst_wb", {31'b0, bus.writeback_block}, 0);
    chk("rst_abort", {31'b0, bus.abort_mem_accs}, 0);
    chk("rst_bus_v", {31'b0, bus.bus_req_valid}, 0);
    chk("rst_snp_rdy", {31'b0, bus.snp_ready}, 1);
    chk("rst_cpu_rdy", {31'b0, bus.cpu_ready}, 1);
    @(negedge clock);
    reset = 1'b0;
    tick();

    // preload blocks both request sides
    bus.init_valid = 1'b1;
    bus.init_idx   = 4'd0;
    bus.init_state = 2'b00;
    #1;
    chk("init_snp_rdy", {31'b0, bus.snp_ready}, 0);
    chk("init_cpu_rdy", {31'b0, bus.cpu_ready}, 0);
    tick();
    bus.init_valid = 1'b0;

    // single request vectors
    for (int i = 0; i < 16; i++) begin
      v = vt[i];
      preload(v.idx, v.pre);
      chk($sformatf("v%0d_pre", i), {30'b0, st_of(v.idx)},
          {30'b0, v.pre});
      if (v.cpu) cpu(v.wr, v.idx);
      else snoop(v.op, v.idx);
      #1;
      if (v.cpu)
        chk($sformatf("v%0d_cpu_rdy", i),
            {31'b0, bus.cpu_ready}, 1);
      else
        chk($sformatf("v%0d_snp_rdy", i),
            {31'b0, bus.snp_ready}, 1);
      e.idx = v.idx;
      e.st  = v.post;
      e.wb  = v.wb;
      e.bv  = v.bv;
      e.bop = v.bop;
      sbq.push_back(e);
      tick();
      idle_inputs();
      if (sbq.size() == 0) begin
        chk($sformatf("v%0d_sbq", i), 0, 1);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("v%0d_state", i),
            {30'b0, st_of(e.idx)}, {30'b0, e.st});
        chk($sformatf("v%0d_wb", i),
            {31'b0, bus.writeback_block}, {31'b0, e.wb});
        chk($sformatf("v%0d_abort", i),
            {31'b0, bus.abort_mem_accs}, {31'b0, e.wb});
        chk($sformatf("v%0d_bus_v", i),
            {31'b0, bus.bus_req_valid}, {31'b0, e.bv});
        if (e.wb)
          chk($sformatf("v%0d_wb_idx", i),
              {28'b0, bus.wb_idx}, {28'b0, e.idx});
        if (e.bv) begin
          chk($sformatf("v%0d_bus_op", i),
              {29'b0, bus.bus_req_op}, {29'b0, e.bop});
          chk($sformatf("v%0d_bus_idx", i),
              {28'b0, bus.bus_req_idx}, {28'b0, e.idx});
        end
        if (e.wb) begin
          bus.wb_ack = 1'b1;
          tick();
          bus.wb_ack = 1'b0;
          chk($sformatf("v%0d_wb_drop", i),
              {31'b0, bus.writeback_block}, 0);
          chk($sformatf("v%0d_snp_rdy2", i),
              {31'b0, bus.snp_ready}, 1);
        end else begin
          tick();
          chk($sformatf("v%0d_pulse_end", i),
              {31'b0, bus.bus_req_valid}, 0);
        end
      end
    end

    // writeback held two cycles before ack
    preload(4'd3, 2'b10);
    snoop(3'b001, 4'd3);
    tick();
    idle_inputs();
    chk("wb2_flag", {31'b0, bus.writeback_block}, 1);
    chk("wb2_abort", {31'b0, bus.abort_mem_accs}, 1);
    chk("wb2_idx", {28'b0, bus.wb_idx}, 32'd3);
    chk("wb2_state", {30'b0, st_of(4'd3)}, 32'd1);
    chk("wb2_snp_rdy", {31'b0, bus.snp_ready}, 0);
    chk("wb2_cpu_rdy", {31'b0, bus.cpu_ready}, 0);
    tick();
    chk("wb2_hold1", {31'b0, bus.writeback_block}, 1);
    tick();
    chk("wb2_hold2", {31'b0, bus.abort_mem_accs}, 1);
    chk("wb2_hold_idx", {28'b0, bus.wb_idx}, 32'd3);
    bus.wb_ack = 1'b1;
    tick();
    bus.wb_ack = 1'b0;
    chk("wb2_drop", {31'b0, bus.writeback_block}, 0);
    chk("wb2_drop_ab", {31'b0, bus.abort_mem_accs}, 0);
    chk("wb2_rdy", {31'b0, bus.snp_ready}, 1);

    // wb_ack in idle is ignored
    bus.wb_ack = 1'b1;
    tick();
    bus.wb_ack = 1'b0;
    chk("ack_idle_wb", {31'b0, bus.writeback_block}, 0);
    chk("ack_idle_rdy", {31'b0, bus.snp_ready}, 1);

    // CPU write miss then back-to-back hit
    preload(4'd7, 2'b00);
    cpu(1'b1, 4'd7);
    tick();
    chk("w7_bus_v", {31'b0, bus.bus_req_valid}, 1);
    chk("w7_bus_op", {29'b0, bus.bus_req_op}, 32'd2);
    chk("w7_bus_idx", {28'b0, bus.bus_req_idx}, 32'd7);
    chk("w7_state", {30'b0, st_of(4'd7)}, 32'd2);
    tick();
    idle_inputs();
    chk("w7_hit_bus_v", {31'b0, bus.bus_req_valid}, 0);
    chk("w7_hit_state", {30'b0, st_of(4'd7)}, 32'd2);

    // same-index snoop beats CPU, CPU retries
    preload(4'd2, 2'b01);
    snoop(3'b010, 4'd2);
    cpu(1'b1, 4'd2);
    #1;
    chk("col_cpu_rdy", {31'b0, bus.cpu_ready}, 0);
    chk("col_snp_rdy", {31'b0, bus.snp_ready}, 1);
    tick();
    bus.snp_valid = 1'b0;
    chk("col_state", {30'b0, st_of(4'd2)}, 32'd0);
    chk("col_bus_v", {31'b0, bus.bus_req_valid}, 0);
    #1;
    chk("retry_rdy", {31'b0, bus.cpu_ready}, 1);
    tick();
    idle_inputs();
    chk("retry_bus_v", {31'b0, bus.bus_req_valid}, 1);
    chk("retry_bus_op", {29'b0, bus.bus_req_op}, 32'd2);
    chk("retry_state", {30'b0, st_of(4'd2)}, 32'd2);

    // different-index snoop and CPU on one edge
    preload(4'd6, 2'b10);
    preload(4'd9, 2'b00);
    snoop(3'b001, 4'd6);
    cpu(1'b0, 4'd9);
    tick();
    idle_inputs();
    chk("dual_wb", {31'b0, bus.writeback_block}, 1);
    chk("dual_st6", {30'b0, st_of(4'd6)}, 32'd1);
    chk("dual_bus_op", {29'b0, bus.bus_req_op}, 32'd1);
    chk("dual_bus_idx", {28'b0, bus.bus_req_idx}, 32'd9);
    chk("dual_st9", {30'b0, st_of(4'd9)}, 32'd1);
    bus.wb_ack = 1'b1;
    tick();
    bus.wb_ack = 1'b0;

    // back-to-back snoops with no writeback
    preload(4'd10, 2'b01);
    preload(4'd11, 2'b01);
    snoop(3'b011, 4'd10);
    tick();
    chk("b2b_rdy", {31'b0, bus.snp_ready}, 1);
    snoop(3'b010, 4'd11);
    tick();
    idle_inputs();
    chk("b2b_st10", {30'b0, st_of(4'd10)}, 32'd0);
    chk("b2b_st11", {30'b0, st_of(4'd11)}, 32'd0);

`ifdef COH_PROTO_ERR_EN
    preload(4'd1, 2'b10);
    chk("perr_pre", {31'b0, proto_err}, 0);
    snoop(3'b011, 4'd1);
    tick();
    idle_inputs();
    chk("perr_set", {31'b0, proto_err}, 1);
    chk("perr_state", {30'b0, st_of(4'd1)}, 32'd2);
    chk("perr_wb", {31'b0, bus.writeback_block}, 0);
    tick();
    tick();
    chk("perr_sticky", {31'b0, proto_err}, 1);
`else
    preload(4'd12, 2'b11);
    snoop(3'b001, 4'd12);
    tick();
    idle_inputs();
    chk("st11_state", {30'b0, st_of(4'd12)}, 32'd3);
    chk("st11_wb", {31'b0, bus.writeback_block}, 0);
`endif

    // async reset during writeback
    preload(4'd4, 2'b10);
    snoop(3'b001, 4'd4);
    tick();
    idle_inputs();
    chk("rwb_flag", {31'b0, bus.writeback_block}, 1);
    reset = 1'b1;
    #1;
    chk("rwb_lines", bus.line_state, 32'h0);
    chk("rwb_wb", {31'b0, bus.writeback_block}, 0);
    chk("rwb_abort", {31'b0, bus.abort_mem_accs}, 0);
    chk("rwb_snp_rdy", {31'b0, bus.snp_ready}, 1);
    chk("rwb_cpu_rdy", {31'b0, bus.cpu_ready}, 1);
`ifdef COH_PROTO_ERR_EN
    chk("rwb_perr", {31'b0, proto_err}, 0);
`endif
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_wb", {31'b0, bus.writeback_block}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
